// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// regfile_sb: multi-read register file with two write ports, zero register,
// write-to-read bypass and per-register pending scoreboard.  Rev 1.0
// ============================================================================
module regfile_sb #(
  parameter int W            = 32,
  parameter int DEPTH        = 32,
  parameter int NREAD        = 2,
  parameter bit ZERO_REG     = 1'b1,
  parameter bit BYPASS       = 1'b1,
  parameter int SPEC_IN_IDX  = 30,
  parameter int SPEC_OUT_IDX = 31,
  localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREAD*AW-1:0] rd_addr,
  output logic [NREAD*W-1:0]  rd_data,
  output logic [NREAD-1:0]    rd_pending,
  input  logic                wa_en,
  input  logic [AW-1:0]       wa_addr,
  input  logic [W-1:0]        wa_data,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic [W-1:0]        wb_data,
  input  logic                sb_set_en,
  input  logic [AW-1:0]       sb_set_addr,
  input  logic [W-1:0]        spec_in,
  output logic [W-1:0]        spec_out,
  output logic                busy
);

  logic [W-1:0]     regs_q [DEPTH];
  logic [W-1:0]     regs_d [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  // Later assignments win: B < A < spec_in for data, clear < set for pending.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      regs_d[r] = regs_q[r];
      pend_d[r] = pend_q[r];
      if (!(ZERO_REG && r == 0)) begin
        if (wb_en && wb_addr == AW'(r)) begin
          regs_d[r] = wb_data;
          pend_d[r] = 1'b0;
        end
        if (wa_en && wa_addr == AW'(r)) begin
          regs_d[r] = wa_data;
        end
        if (r == SPEC_IN_IDX) begin
          regs_d[r] = spec_in;
        end
        if (sb_set_en && sb_set_addr == AW'(r)) begin
          pend_d[r] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  // Next-state values double as the bypass path, so reads follow commit priority.
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic          in_range;
    assign addr     = rd_addr[i*AW +: AW];
    assign in_range = ({1'b0, addr} < (AW+1)'(DEPTH));
    assign rd_data[i*W +: W] = !in_range ? '0 :
                               (BYPASS ? regs_d[addr] : regs_q[addr]);
    assign rd_pending[i]     = in_range && (BYPASS ? pend_d[addr] : pend_q[addr]);
  end

  assign spec_out = regs_q[SPEC_OUT_IDX];
  assign busy     = |pend_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// tb_regfile_sb: scenario bench for regfile_sb with an expected-value queue.
// Rev 1.0
// ============================================================================
module tb_regfile_sb;
  localparam int W     = 32;
  localparam int AW    = 5;
  localparam int NREAD = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREAD*AW-1:0] rd_addr;
  logic [NREAD*W-1:0]  rd_data;
  logic [NREAD-1:0]    rd_pending;
  logic                wa_en, wb_en, sb_set_en;
  logic [AW-1:0]       wa_addr, wb_addr, sb_set_addr;
  logic [W-1:0]        wa_data, wb_data, spec_in, spec_out;
  logic                busy;

  typedef struct {
    logic [W-1:0] data;
    logic         pend;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  regfile_sb dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_pending  (rd_pending),
    .wa_en       (wa_en),
    .wa_addr     (wa_addr),
    .wa_data     (wa_data),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .spec_in     (spec_in),
    .spec_out    (spec_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Inputs change 1 unit after the rising edge; outputs sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    wa_en     = 1'b0;
    wb_en     = 1'b0;
    sb_set_en = 1'b0;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic test_reset();
    step();
    rd_addr = '0;
    rd_addr[0 +: AW] = 5'd0;
    rd_addr[AW +: AW] = 5'd1;
    settle();
    checks++;
    if (rd_data !== '0 || rd_pending !== '0 || busy !== 1'b0 || spec_out !== '0) begin
      errors++;
      $display("FAIL reset_state got data=%0h pend=%b busy=%b spec_out=%0h exp all zero",
               rd_data, rd_pending, busy, spec_out);
    end
    step();
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'd123;
    sb_set_en = 1'b1; sb_set_addr = 5'd5;
    rd_addr[0 +: AW] = 5'd5;
    step();
    sbq.push_back('{data: 32'd123, pend: 1'b1});
    settle();
    e = sbq.pop_front();
    checks++;
    if (rd_data[0 +: W] !== e.data || rd_pending[0] !== e.pend || busy !== 1'b1) begin
      errors++;
      $display("FAIL preload_r5 got data=%0d pend=%b busy=%b exp data=%0d pend=%b busy=1",
               rd_data[0 +: W], rd_pending[0], busy, e.data, e.pend);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sbq.push_back('{data: '0, pend: 1'b0});
    settle();
    e = sbq.pop_front();
    checks++;
    if (rd_data[0 +: W] !== e.data || rd_pending[0] !== e.pend || busy !== 1'b0 || spec_out !== '0) begin
      errors++;
      $display("FAIL reset_r5 got data=%0d pend=%b busy=%b spec_out=%0d exp 0/0/0/0",
               rd_data[0 +: W], rd_pending[0], busy, spec_out);
    end
  endtask

  task automatic test_dual_write();
    step();
    sb_set_en = 1'b1; sb_set_addr = 5'd7;
    step();
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'd10;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'd20;
    rd_addr[0 +: AW] = 5'd7;
    sbq.push_back('{data: 32'd10, pend: 1'b0});
    settle();
    e = sbq.pop_front();
    checks++;
    if (rd_data[0 +: W] !== e.data || rd_pending[0] !== e.pend || busy !== 1'b1) begin
      errors++;
      $display("FAIL dual_bypass got data=%0d pend=%b busy=%b exp data=%0d pend=%b busy=1",
               rd_data[0 +: W], rd_pending[0], busy, e.data, e.pend);
    end
    step();
    sbq.push_back('{data: 32'd10, pend: 1'b0});
    settle();
    e = sbq.pop_front();
    checks++;
    if (rd_data[0 +: W] !== e.data || rd_pending[0] !== e.pend || busy !== 1'b0) begin
      errors++;
      $display("FAIL dual_stored got data=%0d pend=%b busy=%b exp data=%0d pend=%b busy=0",
               rd_data[0 +: W], rd_pending[0], busy, e.data, e.pend);
    end
  endtask

  task automatic test_zero_reg();
    step();
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFF;
    sb_set_en = 1'b1; sb_set_addr = 5'd0;
    rd_addr[0 +: AW] = 5'd0;
    sbq.push_back('{data: '0, pend: 1'b0});
    settle();
    e = sbq.pop_front();
    checks++;
    if (rd_data[0 +: W] !== e.data || rd_pending[0] !== e.pend) begin
      errors++;
      $display("FAIL zero_bypass got data=%0h pend=%b exp data=%0h pend=%b",
               rd_data[0 +: W], rd_pending[0], e.data, e.pend);
    end
    step();
    rd_addr[AW +: AW] = 5'd0;
    sbq.push_back('{data: '0, pend: 1'b0});
    settle();
    e = sbq.pop_front();
    checks++;
    if (rd_data[AW*0 +: W] !== e.data || rd_data[W +: W] !== e.data ||
        rd_pending !== {e.pend, e.pend} || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_stored got data0=%0h data1=%0h pend=%b busy=%b exp 0/0/00/0",
               rd_data[0 +: W], rd_data[W +: W], rd_pending, busy);
    end
  endtask

  task automatic test_scoreboard();
    step();
    sb_set_en = 1'b1; sb_set_addr = 5'd9;
    rd_addr[0 +: AW] = 5'd9;
    settle();
    checks++;
    if (rd_pending[0] !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL sb_set_cycle got pend=%b busy=%b exp pend=1 busy=0", rd_pending[0], busy);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      settle();
      checks++;
      if (rd_pending[0] !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL sb_hold%0d got pend=%b busy=%b exp pend=1 busy=1", k, rd_pending[0], busy);
      end
    end
    step();
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = -32'sd4;
    sbq.push_back('{data: 32'hFFFF_FFFC, pend: 1'b0});
    settle();
    e = sbq.pop_front();
    checks++;
    if (rd_data[0 +: W] !== e.data || rd_pending[0] !== e.pend || busy !== 1'b1) begin
      errors++;
      $display("FAIL sb_wb_cycle got data=%0h pend=%b busy=%b exp data=%0h pend=%b busy=1",
               rd_data[0 +: W], rd_pending[0], busy, e.data, e.pend);
    end
    step();
    sbq.push_back('{data: 32'hFFFF_FFFC, pend: 1'b0});
    settle();
    e = sbq.pop_front();
    checks++;
    if (rd_data[0 +: W] !== e.data || rd_pending[0] !== e.pend || busy !== 1'b0) begin
      errors++;
      $display("FAIL sb_after_wb got data=%0h pend=%b busy=%b exp data=%0h pend=%b busy=0",
               rd_data[0 +: W], rd_pending[0], busy, e.data, e.pend);
    end
  endtask

  task automatic test_collision();
    step();
    sb_set_en = 1'b1; sb_set_addr = 5'd3;
    rd_addr[0 +: AW] = 5'd3;
    step();
    sb_set_en = 1'b1; sb_set_addr = 5'd3;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'd8;
    sbq.push_back('{data: 32'd8, pend: 1'b1});
    settle();
    e = sbq.pop_front();
    checks++;
    if (rd_data[0 +: W] !== e.data || rd_pending[0] !== e.pend) begin
      errors++;
      $display("FAIL collide_bypass got data=%0d pend=%b exp data=%0d pend=%b",
               rd_data[0 +: W], rd_pending[0], e.data, e.pend);
    end
    step();
    sbq.push_back('{data: 32'd8, pend: 1'b1});
    settle();
    e = sbq.pop_front();
    checks++;
    if (rd_data[0 +: W] !== e.data || rd_pending[0] !== e.pend || busy !== 1'b1) begin
      errors++;
      $display("FAIL collide_stored got data=%0d pend=%b busy=%b exp data=%0d pend=%b busy=1",
               rd_data[0 +: W], rd_pending[0], busy, e.data, e.pend);
    end
    step();
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'd8;
    step();
  endtask

  task automatic test_special();
    step();
    spec_in = 32'd77;
    wa_en = 1'b1; wa_addr = 5'd30; wa_data = 32'd5;
    wb_en = 1'b1; wb_addr = 5'd31; wb_data = 32'd9;
    rd_addr[0 +: AW] = 5'd30;
    rd_addr[AW +: AW] = 5'd31;
    sbq.push_back('{data: 32'd77, pend: 1'b0});
    settle();
    e = sbq.pop_front();
    checks++;
    if (rd_data[0 +: W] !== e.data || rd_data[W +: W] !== 32'd9 || spec_out !== 32'd0) begin
      errors++;
      $display("FAIL spec_bypass got r30=%0d r31=%0d spec_out=%0d exp r30=%0d r31=9 spec_out=0",
               rd_data[0 +: W], rd_data[W +: W], spec_out, e.data);
    end
    step();
    sbq.push_back('{data: 32'd77, pend: 1'b0});
    settle();
    e = sbq.pop_front();
    checks++;
    if (rd_data[0 +: W] !== e.data || spec_out !== 32'd9) begin
      errors++;
      $display("FAIL spec_stored got r30=%0d spec_out=%0d exp r30=%0d spec_out=9",
               rd_data[0 +: W], spec_out, e.data);
    end
    step();
    spec_in = '0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d;
    for (int k = 0; k < 4; k++) begin
      step();
      d = $urandom;
      wa_en = 1'b1; wa_addr = AW'(10 + k); wa_data = d;
      sbq.push_back('{data: d, pend: 1'b0});
    end
    for (int k = 0; k < 4; k++) begin
      step();
      rd_addr[AW +: AW] = AW'(10 + k);
      rd_addr[0 +: AW]  = AW'(13 - k);
      settle();
      e = sbq.pop_front();
      checks++;
      if (rd_data[W +: W] !== e.data || rd_pending[1] !== e.pend) begin
        errors++;
        $display("FAIL b2b_r%0d got data=%0h pend=%b exp data=%0h pend=%b",
                 10 + k, rd_data[W +: W], rd_pending[1], e.data, e.pend);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    wa_en = 1'b0; wa_addr = '0; wa_data = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    sb_set_en = 1'b0; sb_set_addr = '0;
    spec_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_dual_write();
    test_zero_reg();
    test_scoreboard();
    test_collision();
    test_special();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired before the scenario sequence completed");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
